// File: rtl/mips_pkg.sv
// MIPS opcode/funct constants and issue-FSM state type shared by the dual-issue front end.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_IALU_LO = 6'h08;
  localparam logic [5:0] OP_IALU_HI = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } issue_state_t;

endpackage

// File: rtl/dual_issue_pair_check.sv
// Combinational hazard check between the older (ins_a) and younger (ins_b) instruction of a fetched pair.
module dual_issue_pair_check
  import mips_pkg::*;
(
  input  logic [31:0] ins_a,
  input  logic [31:0] ins_b,
  output logic        conflict
);

  typedef struct packed {
    logic       wr_en;
    logic [4:0] wr_reg;
    logic       rd_rs;
    logic       rd_rt;
    logic       mem;
    logic       ctl;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    op = ins[31:26];
    d  = '0;
    // The all-zero word is the IF/ID reset content and decodes as a pure NOP.
    if (ins != '0) begin
      if (op == OP_RTYPE) begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        if (ins[5:0] == FN_JR) begin
          d.ctl = 1'b1;
        end else begin
          d.wr_en  = 1'b1;
          d.wr_reg = ins[15:11];
        end
      end else if (op >= OP_IALU_LO && op <= OP_IALU_HI) begin
        d.rd_rs  = 1'b1;
        d.wr_en  = 1'b1;
        d.wr_reg = ins[20:16];
      end else if (op == OP_LW) begin
        d.rd_rs  = 1'b1;
        d.wr_en  = 1'b1;
        d.wr_reg = ins[20:16];
        d.mem    = 1'b1;
      end else if (op == OP_SW) begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        d.mem   = 1'b1;
      end else if (op == OP_BEQ || op == OP_BNE) begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        d.ctl   = 1'b1;
      end else if (op == OP_J) begin
        d.ctl = 1'b1;
      end else if (op == OP_JAL) begin
        d.ctl    = 1'b1;
        d.wr_en  = 1'b1;
        d.wr_reg = REG_RA;
      end
    end
    if (d.wr_reg == 5'd0) d.wr_en = 1'b0;
    return d;
  endfunction

  dec_t dec_a;
  dec_t dec_b;

  always_comb begin
    dec_a    = decode(ins_a);
    dec_b    = decode(ins_b);
    conflict = (dec_a.wr_en && dec_b.rd_rs && ins_b[25:21] == dec_a.wr_reg)
            || (dec_a.wr_en && dec_b.rd_rt && ins_b[20:16] == dec_a.wr_reg)
            || (dec_a.wr_en && dec_b.wr_en && dec_a.wr_reg == dec_b.wr_reg)
            || (dec_a.mem && dec_b.mem)
            || dec_a.ctl;
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue scheduler: issues the IF/ID pair together or splits it over two cycles, drives IF stall/flush.
module dual_issue_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pr_pc,
  input  logic [31:0]      pr_instr1,
  input  logic [31:0]      pr_instr2,
  input  logic             hold,
  input  logic             redirect,
  output logic             issue0_valid,
  output logic [31:0]      issue0_instr,
  output logic [31:0]      issue0_pc,
  output logic             issue1_valid,
  output logic [31:0]      issue1_instr,
  output logic [31:0]      issue1_pc,
  output logic             if_stall,
  output logic             if_flush,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] single_cnt
);

  issue_state_t state, state_nxt;
  logic         conflict;
  logic         pair_inc;
  logic         single_inc;
  logic [31:0]  pc_plus4;

  dual_issue_pair_check u_pair_check (
    .ins_a    (pr_instr1),
    .ins_b    (pr_instr2),
    .conflict (conflict)
  );

  assign pc_plus4     = pr_pc + 32'd4;
  assign issue1_instr = pr_instr2;
  assign issue1_pc    = pc_plus4;

  always_comb begin
    state_nxt    = state;
    issue0_valid = 1'b0;
    issue1_valid = 1'b0;
    if_stall     = 1'b0;
    if_flush     = 1'b0;
    pair_inc     = 1'b0;
    single_inc   = 1'b0;
    issue0_instr = (state == ST_SPLIT) ? pr_instr2 : pr_instr1;
    issue0_pc    = (state == ST_SPLIT) ? pc_plus4  : pr_pc;
    // Control outputs are gated by reset so they drop immediately, not at the next edge.
    if (!reset) begin
      if (redirect) begin
        if_flush  = 1'b1;
        state_nxt = ST_PAIR;
      end else if (hold) begin
        if_stall = 1'b1;
      end else begin
        issue0_valid = 1'b1;
        unique case (state)
          ST_PAIR: begin
            if (conflict) begin
              if_stall   = 1'b1;
              single_inc = 1'b1;
              state_nxt  = ST_SPLIT;
            end else begin
              issue1_valid = 1'b1;
              pair_inc     = 1'b1;
            end
          end
          ST_SPLIT: begin
            single_inc = 1'b1;
            state_nxt  = ST_PAIR;
          end
          default: state_nxt = ST_PAIR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PAIR;
      pair_cnt   <= '0;
      single_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pair_inc)   pair_cnt   <= pair_cnt + 1'b1;
      if (single_inc) single_cnt <= single_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Self-checking bench for dual_issue_ctrl: directed scenarios plus randomized traffic against a mask-based model.
module tb_dual_issue_ctrl;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          reset;
  logic [31:0]   pr_pc, pr_instr1, pr_instr2;
  logic          hold, redirect;
  logic          issue0_valid, issue1_valid, if_stall, if_flush;
  logic [31:0]   issue0_instr, issue0_pc, issue1_instr, issue1_pc;
  logic [CW-1:0] pair_cnt, single_cnt;

  int checks = 0;
  int errors = 0;

  dual_issue_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pr_pc        (pr_pc),
    .pr_instr1    (pr_instr1),
    .pr_instr2    (pr_instr2),
    .hold         (hold),
    .redirect     (redirect),
    .issue0_valid (issue0_valid),
    .issue0_instr (issue0_instr),
    .issue0_pc    (issue0_pc),
    .issue1_valid (issue1_valid),
    .issue1_instr (issue1_instr),
    .issue1_pc    (issue1_pc),
    .if_stall     (if_stall),
    .if_flush     (if_flush),
    .pair_cnt     (pair_cnt),
    .single_cnt   (single_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: register sets as 32-bit masks ----------------
  function automatic logic [31:0] wmask(input logic [31:0] ins);
    logic [5:0]  op;
    logic [31:0] m;
    op = ins[31:26];
    m  = 32'h0;
    if (ins == 32'h0)                                m = 32'h0;
    else if (op == 6'h00 && ins[5:0] != 6'h08)        m = 32'h1 << ins[15:11];
    else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) m = 32'h1 << ins[20:16];
    else if (op == 6'h03)                            m = 32'h8000_0000;
    return m & ~32'h1;
  endfunction

  function automatic logic [31:0] rmask(input logic [31:0] ins);
    logic [5:0]  op;
    logic [31:0] m;
    op = ins[31:26];
    m  = 32'h0;
    if (ins == 32'h0) m = 32'h0;
    else if (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05)
      m = (32'h1 << ins[25:21]) | (32'h1 << ins[20:16]);
    else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23)
      m = 32'h1 << ins[25:21];
    return m & ~32'h1;
  endfunction

  function automatic logic is_mem(input logic [31:0] ins);
    return ins[31:26] == 6'h23 || ins[31:26] == 6'h2B;
  endfunction

  function automatic logic is_ctl(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return ins != 32'h0 && (op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
                            (op == 6'h00 && ins[5:0] == 6'h08));
  endfunction

  function automatic logic model_conflict(input logic [31:0] a, input logic [31:0] b);
    return (|(wmask(a) & rmask(b))) || (|(wmask(a) & wmask(b))) ||
           (is_mem(a) && is_mem(b)) || is_ctl(a);
  endfunction

  logic          m_pend;
  logic [CW-1:0] m_pair, m_single;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend   <= 1'b0;
      m_pair   <= '0;
      m_single <= '0;
    end else if (redirect) begin
      m_pend <= 1'b0;
    end else if (!hold) begin
      if (m_pend) begin
        m_pend   <= 1'b0;
        m_single <= m_single + 1'b1;
      end else if (model_conflict(pr_instr1, pr_instr2)) begin
        m_pend   <= 1'b1;
        m_single <= m_single + 1'b1;
      end else begin
        m_pair <= m_pair + 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge, mid-way between input changes and clock edges.
  always @(negedge clk) begin
    logic run, conf;
    run  = !reset && !redirect && !hold;
    conf = model_conflict(pr_instr1, pr_instr2);
    chk("v0",     32'(issue0_valid), 32'(run));
    chk("v1",     32'(issue1_valid), 32'(run && !m_pend && !conf));
    chk("stall",  32'(if_stall),     32'(!reset && !redirect && (hold || (!m_pend && conf))));
    chk("flush",  32'(if_flush),     32'(!reset && redirect));
    chk("i0",     issue0_instr,      m_pend ? pr_instr2 : pr_instr1);
    chk("pc0",    issue0_pc,         m_pend ? pr_pc + 32'd4 : pr_pc);
    chk("i1",     issue1_instr,      pr_instr2);
    chk("pc1",    issue1_pc,         pr_pc + 32'd4);
    chk("paircnt", 32'(pair_cnt),    32'(m_pair));
    chk("singcnt", 32'(single_cnt),  32'(m_single));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return 32'h0;
      1, 11: begin
        case ($urandom_range(0, 2))
          0: fn = 6'h20;
          1: fn = 6'h22;
          default: fn = 6'h08;
        endcase
        return {6'h00, rreg(), rreg(), rreg(), 5'd0, fn};
      end
      2, 3: op = 6'h08 + 6'($urandom_range(0, 7));
      4:  op = 6'h23;
      5:  op = 6'h2B;
      6:  op = 6'h04;
      7:  op = 6'h05;
      8:  op = 6'h02;
      9:  op = 6'h03;
      default: return $urandom;
    endcase
    return {op, rreg(), rreg(), imm};
  endfunction

  localparam logic [31:0] ADD  = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20};  // add $8,$9,$10
  localparam logic [31:0] ADDI = {6'h08, 5'd12, 5'd11, 16'd5};             // addi $11,$12,5
  localparam logic [31:0] SUB  = {6'h00, 5'd8, 5'd12, 5'd11, 5'd0, 6'h22}; // sub $11,$8,$12
  localparam logic [31:0] LW   = {6'h23, 5'd9, 5'd8, 16'd0};               // lw $8,0($9)
  localparam logic [31:0] SW   = {6'h2B, 5'd11, 5'd10, 16'd4};             // sw $10,4($11)
  localparam logic [31:0] ADDI0 = {6'h08, 5'd1, 5'd0, 16'd1};              // addi $0,$1,1
  localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd0, 5'd2, 5'd0, 6'h20};   // add $2,$0,$0
  localparam logic [31:0] BEQ  = {6'h04, 5'd1, 5'd2, 16'd3};               // beq $1,$2,L
  localparam logic [31:0] ADDX = {6'h00, 5'd4, 5'd5, 5'd3, 5'd0, 6'h20};   // add $3,$4,$5

  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    pr_pc     = pc;
    pr_instr1 = a;
    pr_instr2 = b;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; redirect = 1'b0;
    drive(32'h0, 32'h0, 32'h0);

    chk("pin_conf_add_sub", 32'(model_conflict(ADD, SUB)), 32'd1);
    chk("pin_conf_reg0",    32'(model_conflict(ADDI0, ADD0)), 32'd0);
    chk("pin_conf_mem",     32'(model_conflict(LW, SW)), 32'd1);

    tick();
    chk("rst_v0", 32'(issue0_valid), 32'd0);
    chk("rst_stall", 32'(if_stall), 32'd0);
    chk("rst_pair", 32'(pair_cnt), 32'd0);
    chk("rst_single", 32'(single_cnt), 32'd0);
    reset = 1'b0;

    // 1: independent pair
    drive(32'h100, ADD, ADDI);
    #3;
    chk("t1_v0", 32'(issue0_valid), 32'd1);
    chk("t1_v1", 32'(issue1_valid), 32'd1);
    chk("t1_pc0", issue0_pc, 32'h100);
    chk("t1_pc1", issue1_pc, 32'h104);
    chk("t1_stall", 32'(if_stall), 32'd0);
    chk("t1_pair_before", 32'(pair_cnt), 32'd0);
    tick();
    chk("t1_pair_after", 32'(pair_cnt), 32'd1);

    // 2: RAW hazard splits
    drive(32'h100, ADD, SUB);
    #3;
    chk("t2_i0", issue0_instr, ADD);
    chk("t2_stall", 32'(if_stall), 32'd1);
    chk("t2_v1", 32'(issue1_valid), 32'd0);
    tick(); #3;
    chk("t2_split_i0", issue0_instr, SUB);
    chk("t2_split_pc0", issue0_pc, 32'h104);
    chk("t2_split_stall", 32'(if_stall), 32'd0);
    tick();
    chk("t2_single", 32'(single_cnt), 32'd2);

    // 3: two memory ops split; $0 destination never conflicts
    drive(32'h200, LW, SW);
    #3;
    chk("t3_stall", 32'(if_stall), 32'd1);
    tick(); #3;
    chk("t3_split_i0", issue0_instr, SW);
    tick();
    drive(32'h300, ADDI0, ADD0);
    #3;
    chk("t3_r0_v1", 32'(issue1_valid), 32'd1);
    tick();
    chk("t3_pair", 32'(pair_cnt), 32'd2);
    chk("t3_single", 32'(single_cnt), 32'd4);

    // 4: branch splits, redirect in the SPLIT cycle
    drive(32'h400, BEQ, ADDX);
    #3;
    chk("t4_stall", 32'(if_stall), 32'd1);
    tick();
    redirect = 1'b1;
    #3;
    chk("t4_v0", 32'(issue0_valid), 32'd0);
    chk("t4_flush", 32'(if_flush), 32'd1);
    chk("t4_stall_redir", 32'(if_stall), 32'd0);
    tick();
    redirect = 1'b0;
    chk("t4_single", 32'(single_cnt), 32'd5);
    drive(32'h500, 32'h0, 32'h0);
    #3;
    chk("t4_back_pair", 32'(issue1_valid), 32'd1);
    tick();
    chk("t4_pair", 32'(pair_cnt), 32'd3);

    // 5: hold for two cycles while SPLIT
    drive(32'h600, ADD, SUB);
    tick();
    hold = 1'b1;
    #3;
    chk("t5_h1_v0", 32'(issue0_valid), 32'd0);
    chk("t5_h1_stall", 32'(if_stall), 32'd1);
    tick(); #3;
    chk("t5_h2_v0", 32'(issue0_valid), 32'd0);
    chk("t5_h2_stall", 32'(if_stall), 32'd1);
    tick();
    hold = 1'b0;
    #3;
    chk("t5_rel_i0", issue0_instr, SUB);
    chk("t5_rel_v0", 32'(issue0_valid), 32'd1);
    tick();
    chk("t5_single", 32'(single_cnt), 32'd7);
    chk("t5_pair", 32'(pair_cnt), 32'd3);

    // 6: reset mid-SPLIT, then a NOP pair at the wrapping PC
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_v0", 32'(issue0_valid), 32'd0);
    chk("t6_stall", 32'(if_stall), 32'd0);
    chk("t6_pair", 32'(pair_cnt), 32'd0);
    chk("t6_single", 32'(single_cnt), 32'd0);
    tick();
    reset = 1'b0;
    drive(32'hFFFF_FFFC, 32'h0, 32'h0);
    #3;
    chk("t6_nop_v0", 32'(issue0_valid), 32'd1);
    chk("t6_nop_v1", 32'(issue1_valid), 32'd1);
    chk("t6_pc_wrap", issue1_pc, 32'h0);
    tick();
    chk("t6_pair_after", 32'(pair_cnt), 32'd1);

    // randomized traffic, long enough for the 8-bit counters to wrap
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset    = reset ? 1'b0 : ($urandom_range(0, 199) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3),
            rand_instr(), rand_instr());
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
